// File: rtl/gate4_tt_sequencer.sv
// Truth-table sequencer for a 4-input, 1-output gate: walks patterns 0..15, settles, samples, counts mismatches.
// Optional first-failure capture ports are enabled by defining GATE4_TT_FAIL_CAPTURE_EN.
module gate4_tt_sequencer #(
   parameter logic [15:0] EXPECT_TT  = 16'h7FFF,
   parameter int unsigned SETTLE_CYC = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_f,
   output logic       o_a,
   output logic       o_b,
   output logic       o_c,
   output logic       o_d,
   output logic [3:0] o_pattern,
   output logic       o_busy,
   output logic       o_done,
   output logic [4:0] o_err_cnt,
`ifdef GATE4_TT_FAIL_CAPTURE_EN
   output logic       o_fail_seen,
   output logic [3:0] o_first_fail,
`endif
   output logic       o_pass
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   // A settle time of 0 behaves like 1, so the last count value is clamped at 0.
   localparam logic [7:0] SETTLE_LAST = (SETTLE_CYC == 0) ? 8'd0 : 8'(SETTLE_CYC - 1);

   logic [1:0] r_state;
   logic [3:0] r_pattern;
   logic [7:0] r_cnt;
   logic [4:0] r_err_cnt;
   logic       r_busy;
   logic       r_done;
   logic       w_expect;
   logic       w_mismatch;
`ifdef GATE4_TT_FAIL_CAPTURE_EN
   logic       r_fail_seen;
   logic [3:0] r_first_fail;
`endif

   assign w_expect   = EXPECT_TT[r_pattern];
   // NOTE: case inequality makes an X or Z on the gate output count as a mismatch rather than propagate X.
   assign w_mismatch = (i_f !== w_expect);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_pattern    <= 4'd0;
         r_cnt        <= 8'd0;
         r_err_cnt    <= 5'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
`ifdef GATE4_TT_FAIL_CAPTURE_EN
         r_fail_seen  <= 1'b0;
         r_first_fail <= 4'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (i_start) begin
                  r_state      <= ST_SETTLE;
                  r_pattern    <= 4'd0;
                  r_cnt        <= 8'd0;
                  r_err_cnt    <= 5'd0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
`ifdef GATE4_TT_FAIL_CAPTURE_EN
                  r_fail_seen  <= 1'b0;
                  r_first_fail <= 4'd0;
`endif
               end
            end
            ST_SETTLE: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_state <= ST_SAMPLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            ST_SAMPLE: begin
               if (w_mismatch) begin
                  r_err_cnt <= r_err_cnt + 5'd1;
`ifdef GATE4_TT_FAIL_CAPTURE_EN
                  if (!r_fail_seen) begin
                     r_fail_seen  <= 1'b1;
                     r_first_fail <= r_pattern;
                  end
`endif
               end
               if (r_pattern == 4'hF) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_pattern <= r_pattern + 4'd1;
                  r_cnt     <= 8'd0;
                  r_state   <= ST_SETTLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign o_a       = r_pattern[3];
   assign o_b       = r_pattern[2];
   assign o_c       = r_pattern[1];
   assign o_d       = r_pattern[0];
   assign o_pattern = r_pattern;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_err_cnt = r_err_cnt;
   assign o_pass    = r_done && (r_err_cnt == 5'd0);
`ifdef GATE4_TT_FAIL_CAPTURE_EN
   assign o_fail_seen  = r_fail_seen;
   assign o_first_fail = r_first_fail;
`endif

endmodule

// File: doc/gate4_tt_sequencer.md
Name: gate4_tt_sequencer

Overview:
- Clocked stimulus/response stage for any 4-input, 1-output combinational gate (NAND4 and its sibling styles).
- Drives all 16 input patterns onto the gate under test in ascending order and waits a programmable settle time.
- Samples the gate output, compares it against an expected truth table and reports the mismatch count plus pass/done status.
- Sits directly upstream of the gate (feeds a..d) and downstream of it (consumes f).

Parameters:
- EXPECT_TT, 16'h7FFF, expected output per pattern; bit p = expected f for pattern p. Default is NAND4: only pattern 15 gives 0.
- SETTLE_CYC, 4, cycles the pattern is held before sampling. Legal range 1..255; a value of 0 is treated as 1.

Ports:
- i_clk, input, 1, rising-edge clock.
- i_rst_n, input, 1, reset; asynchronous, active-low.
- i_start, input, 1, start request; sampled only in IDLE and DONE.
- i_f, input, 1, gate-under-test output.
- o_a, output, 1, pattern bit 3 (MSB).
- o_b, output, 1, pattern bit 2.
- o_c, output, 1, pattern bit 1.
- o_d, output, 1, pattern bit 0 (LSB).
- o_pattern, output, 4, current pattern index, for debug.
- o_busy, output, 1, high in SETTLE and SAMPLE.
- o_done, output, 1, high in DONE (level, held).
- o_err_cnt, output, 5, mismatch count, 0..16.
- o_pass, output, 1, o_done && (o_err_cnt == 0).

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; pattern = 0, so o_a..o_d = 0.
  - settle count = 0; o_err_cnt = 0.
  - o_busy = o_done = o_pass = 0.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered and update only on state transitions.
- IDLE:
  - On a clock edge with i_start=1: pattern <= 0, cnt <= 0, o_err_cnt <= 0, go to SETTLE.
  - Otherwise stay; outputs hold.
- SETTLE:
  - cnt increments each cycle.
  - When cnt == SETTLE_CYC-1, go to SAMPLE.
  - i_start is ignored.
- SAMPLE (one cycle):
  - If i_f !== EXPECT_TT[pattern], o_err_cnt increments. Case-inequality is used, so X/Z on i_f counts as a mismatch.
  - If pattern == 15, go to DONE.
  - Otherwise pattern increments, cnt <= 0, go to SETTLE.
- DONE:
  - o_done=1; o_a..o_d hold 4'hF; o_err_cnt holds.
  - i_start=1 restarts exactly as from IDLE; o_done drops on the same edge.
- Timing: each pattern takes SETTLE_CYC+1 cycles.
  - With start sampled at edge E0, pattern p is driven from E0+(SETTLE_CYC+1)*p.
  - o_done rises at E0+16*(SETTLE_CYC+1); default 80 cycles.
- o_err_cnt is 5 bits, so the maximum value of 16 cannot overflow.
- i_start held high continuously: one run per start from IDLE, and an immediate restart from DONE.
- Reset asserted mid-run: everything is cleared immediately and no result is reported.

Optional Feature:
- Macro: GATE4_TT_FAIL_CAPTURE_EN.
- Defined: adds two outputs.
  - o_fail_seen (1): set on the first mismatch of a run.
  - o_first_fail (4): pattern index of that first mismatch; later mismatches do not overwrite it.
  - Both are cleared by reset and by the start of a run.
- Undefined: neither port exists and there is no capture logic. All other behaviour is identical.

Test Plan:
- Correct NAND4 model, default parameters, start pulse:
  - o_a..o_d step 0000..1111, each held 5 cycles.
  - o_done at start+80; o_err_cnt=0; o_pass=1.
- i_f stuck at 1:
  - o_err_cnt=1; o_pass=0.
  - With the macro: o_first_fail=4'hF, o_fail_seen=1.
- i_f stuck at 0:
  - o_err_cnt=15.
  - With the macro: o_first_fail=4'h0.
- i_start pulsed during SETTLE of pattern 6: ignored; run completes at start+80 with no change in sequencing.
- i_rst_n low during pattern 9: outputs go to reset values immediately. After release plus a start pulse, the full run repeats with o_err_cnt starting at 0.
- SETTLE_CYC=1, start from DONE with the previous o_err_cnt=3: o_err_cnt clears on the start edge; o_done rises 32 cycles later.
